// File: rtl/wishbone_arbiter.sv
// -----------------------------------------------------------------------------
// wishbone_arbiter
//
// Two-master round-robin arbiter for the shared Wishbone bus, with a bus
// timeout watchdog. Master 0 is normally the CPU-side master, master 1 a
// second master such as a DMA engine or debug loader. The winning master owns
// the shared bus until it drops cyc; the bus then spends one idle cycle
// (gnt=00) before the next owner is chosen.
//
// The watchdog counts strobe cycles that see no ack. If the slave never
// answers, the owner gets a single-cycle err pulse and s_stb is held low in
// that cycle, so an access to an unmapped address cannot hang a master.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low reset
//   m0_cyc / m1_cyc     bus request / cycle from each master
//   m0_stb / m1_stb     strobe from each master
//   m0_we  / m1_we      write enable from each master
//   m0_adr / m1_adr     address from each master            [ADR_W]
//   m0_dat_o / m1_dat_o write data from each master         [DAT_W]
//   m0_dat_i / m1_dat_i read data returned to each master   [DAT_W]
//   m0_ack / m1_ack     ack returned to each master
//   m0_err / m1_err     watchdog timeout error to each master
//   s_cyc, s_stb, s_we  shared bus controls
//   s_adr, s_dat_o      shared bus address / write data
//   s_dat_i, s_ack      shared bus read data / ack (OR of all slaves)
//   gnt                 one-hot current owner, 00 = bus idle
// -----------------------------------------------------------------------------
module wishbone_arbiter #(
  parameter int unsigned TIMEOUT = 16,  // legal range 2..255
  parameter int unsigned ADR_W   = 16,
  parameter int unsigned DAT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             m0_cyc,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [DAT_W-1:0] m0_dat_o,
  output logic [DAT_W-1:0] m0_dat_i,
  output logic             m0_ack,
  output logic             m0_err,

  input  logic             m1_cyc,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [DAT_W-1:0] m1_dat_o,
  output logic [DAT_W-1:0] m1_dat_i,
  output logic             m1_ack,
  output logic             m1_err,

  output logic             s_cyc,
  output logic             s_stb,
  output logic             s_we,
  output logic [ADR_W-1:0] s_adr,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack,

  output logic [1:0]       gnt
);

  // The state encoding is the one-hot grant itself, so gnt comes straight
  // from the state register and is the only select for the output mux.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  // Err is registered, so it must be scheduled one cycle before the counter
  // would reach TIMEOUT-1; the err cycle is then the TIMEOUT-th stb cycle.
  localparam logic [7:0] ERR_AT = 8'(TIMEOUT - 2);

  state_e     state_q, state_d;
  logic       last_q,  last_d;   // 1: master 1 was granted most recently
  logic [7:0] cnt_q,   cnt_d;    // strobe cycles without ack
  logic       err_q,   err_d;    // one-cycle timeout pulse for the owner

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;           // master 0 wins the first tie
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, round-robin and watchdog
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case statement so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = '0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie, grant whichever master was not granted last.
        if (m0_cyc && (!m1_cyc || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (m1_cyc) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0:    if (!m0_cyc) state_d = IDLE;
      OWN1:    if (!m1_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The counter only runs while the owner keeps the bus with a strobe
    // outstanding; an ack, an idle strobe or any state change clears it.
    if (state_q != IDLE && state_d == state_q && s_stb && !s_ack) begin
      if (cnt_q == ERR_AT) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mux, selected only by the registered grant
  // ---------------------------------------------------------------------------
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_o  = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_dat_i = '0;
    m1_dat_i = '0;

    case (state_q)
      OWN0: begin
        s_cyc    = 1'b1;
        s_stb    = m0_stb & ~err_q;   // strobe withdrawn during the err cycle
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_o  = m0_dat_o;
        m0_ack   = s_ack & ~err_q;    // ack and err are mutually exclusive
        m0_dat_i = s_dat_i;
      end
      OWN1: begin
        s_cyc    = 1'b1;
        s_stb    = m1_stb & ~err_q;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_o  = m1_dat_o;
        m1_ack   = s_ack & ~err_q;
        m1_dat_i = s_dat_i;
      end
      default: ;
    endcase
  end

  assign m0_err = err_q & (state_q == OWN0);
  assign m1_err = err_q & (state_q == OWN1);
  assign gnt    = state_q;

endmodule

// File: doc/wishbone_arbiter.md
Name: wishbone_arbiter

Overview:
- Two-master round-robin arbiter for the shared Wishbone bus.
- Sits between the CPU-side whisbone_master (port 0) and a second bus master (port 1, e.g. DMA or debug loader). Drives the single shared bus that fans out to all wishbone_slave instances.
- Adds a bus-timeout watchdog: an access to an unmapped address (no slave acks) terminates with an error pulse instead of hanging the requester.

Parameters:
- TIMEOUT, 16: cycles with stb asserted and no ack before the watchdog fires; legal range 2..255.
- ADR_W, 16: address width.
- DAT_W, 8: data width.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- m0_cyc  in  1  master 0 bus request / cycle.
- m0_stb  in  1  master 0 strobe.
- m0_we  in  1  master 0 write enable.
- m0_adr  in  ADR_W  master 0 address.
- m0_dat_o  in  DAT_W  master 0 write data.
- m0_dat_i  out  DAT_W  read data to master 0.
- m0_ack  out  1  ack to master 0.
- m0_err  out  1  timeout error to master 0.
- m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_o, m1_dat_i, m1_ack, m1_err: same as master 0, for master 1.
- s_cyc  out  1  shared bus cyc.
- s_stb  out  1  shared bus stb.
- s_we  out  1  shared bus we.
- s_adr  out  ADR_W  shared bus address.
- s_dat_o  out  DAT_W  shared bus write data.
- s_dat_i  in  DAT_W  shared bus read data (OR of slaves).
- s_ack  in  1  shared bus ack.
- gnt  out  2  one-hot current owner; 00 = bus idle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, gnt=00, last=1 (master 0 wins the first tie), timeout counter=0, all m*_err=0.
  - Combinational outputs then evaluate to: s_cyc=s_stb=s_we=0, s_adr=0, s_dat_o=0, m*_ack=0, m*_dat_i=0.
- States: IDLE, OWN0, OWN1.
- IDLE:
  - Only m0_cyc -> OWN0. Only m1_cyc -> OWN1.
  - Both asserted -> grant the master that is not `last`; `last` is updated on every grant.
  - Neither asserted -> stay in IDLE.
- Grant latency: exactly one clock from cyc sampled high in IDLE to gnt/s_cyc high.
- OWNn:
  - Shared bus outputs (cyc, stb, we, adr, dat_o) are a combinational mux of master n.
  - m_n_ack = s_ack; m_n_dat_i = s_dat_i.
  - The non-owner sees ack=0, err=0, dat_i=0.
  - The owner is never preempted while m_n_cyc=1 (multi-beat cycles stay locked).
  - m_n_cyc sampled 0 -> IDLE. The bus is idle for one cycle (gnt=00) between owners; there is no back-to-back handover.
- Watchdog:
  - Counter increments each cycle in OWNn with s_stb=1 and s_ack=0.
  - Counter clears on s_ack=1, on s_stb=0, or on any state change.
  - When the counter reaches TIMEOUT-1 with s_ack still 0: m_n_err is registered high for exactly one cycle, the counter clears, and s_stb is forced 0 during that err cycle.
  - The owner keeps the grant; the master must drop cyc or retry.
  - ack and err never assert in the same cycle. If s_ack arrives in the cycle the counter reaches TIMEOUT-1, ack wins and no err is generated.
- Simultaneous events:
  - In OWN0, if m0_cyc drops in the same cycle m1_cyc rises, go to IDLE and then grant 1 on the following cycle.
  - A request from the non-owner is held pending indefinitely; there is no starvation, because round-robin applies on the next IDLE.
- Reset mid-transfer: the bus is released immediately (asynchronous), with no ack or err delivered.
- gnt is registered and is the sole source of the output mux select. No combinational path exists from m*_cyc to s_cyc.

Test Plan:
- Single master:
  - m0 reads 0x0005 (slave 0 acks after 2 cycles, data 0xA5).
  - Expect gnt=01 one cycle after m0_cyc, s_adr=0x0005, m0_ack for 1 cycle, m0_dat_i=0xA5, m1_ack=0 throughout.
- Tie:
  - After reset, m0_cyc and m1_cyc rise in the same cycle.
  - Expect gnt=01 first. After m0 drops cyc: one IDLE cycle with gnt=00, then gnt=10.
  - Next tie: expect gnt=01 again (alternation).
- Lock:
  - m0 holds cyc across 3 writes (0x1000..0x1002, data 0x11,0x22,0x33) while m1_cyc=1 throughout.
  - Expect gnt to stay 01 for all 3 acks, each write landing in memory 2; m1 granted only after m0_cyc falls.
- Timeout:
  - m1 reads 0x3000 (no slave decodes it), TIMEOUT=16.
  - Expect m1_err high exactly on the 16th cycle of stb with no ack, s_stb=0 in that cycle, m1_ack never high.
- Late ack:
  - Slave acks on the cycle the counter reaches 15.
  - Expect m0_ack=1 and m0_err=0.
- Reset mid-cycle:
  - Assert reset low during an OWN1 read with stb pending.
  - Expect gnt=00, s_cyc=0, m1_ack=m1_err=0 immediately without waiting for clk.
  - After release, a tie grants master 0.
